// File: rtl/fsm_calibration_multi.sv
// Multi-channel calibration sequencer. It arms on start, waits for a debounced fast-gate edge,
// skips a set number of phase edges, fires per-channel delayed pulses, then holds off.
//  state   | meaning
//  IDLE    | waiting for start rising edge
//  ARM     | waiting for fast-gate edge, timeout running
//  PHASE   | counting phase-reference edges
//  FIRE    | delay counter running, triggers pulsing
//  HOLDOFF | min spacing + detector-ready gate
//  DONE    | run complete, waiting for start low
//  ERROR   | fast-gate timeout, waiting for start low
module fsm_calibration_multi #(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DLY_W           = 12,
  parameter int unsigned PH_W            = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned PULSE_CYCLES    = 4,
  parameter int unsigned HOLDOFF_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES  = 8_000_000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start_signal,
  input  logic                    fg_signal,
  input  logic                    phase_signal,
  input  logic                    detector_ready,
  input  logic [1:0]              mode,
  input  logic [CNT_W-1:0]        shot_count,
  input  logic [PH_W-1:0]         phase_skip,
  input  logic [NUM_CH*DLY_W-1:0] channel_delay,
  input  logic [NUM_CH-1:0]       channel_enable,
  output logic [NUM_CH-1:0]       output_trigger,
  output logic                    busy,
  output logic [2:0]              scenario_state,
  output logic [CNT_W-1:0]        counter_out,
  output logic                    timeout_error
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_PHASE   = 3'd2,
    S_FIRE    = 3'd3,
    S_HOLDOFF = 3'd4,
    S_DONE    = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic                    fg_db_q, fg_db_d;
  logic [DBW-1:0]          db_cnt_q, db_cnt_d;
  logic                    start_prev_q, fg_prev_q, ph_prev_q;
  logic [31:0]             tmr_q, tmr_d;
  logic [PH_W-1:0]         ph_cnt_q, ph_cnt_d;
  logic [1:0]              mode_q, mode_d;
  logic [CNT_W-1:0]        shots_q, shots_d;
  logic [PH_W-1:0]         skip_q, skip_d;
  logic [NUM_CH*DLY_W-1:0] dly_q, dly_d;
  logic [NUM_CH-1:0]       en_q, en_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_CH-1:0]       trig_q, trig_d;
  logic                    busy_q, busy_d;
  logic                    tmo_q, tmo_d;

  logic start_s, fg_s, ph_s, rdy_s;
  logic start_rise, fg_rise, ph_rise;
  logic [DLY_W-1:0] max_d;
  logic any_en;
  logic [31:0] fire_end;
  logic [CNT_W-1:0] shots_eff;
  logic hold_met, tmo_hit;

  assign start_s = sync_q[SYNC_STAGES-1][0];
  assign fg_s    = sync_q[SYNC_STAGES-1][1];
  assign ph_s    = sync_q[SYNC_STAGES-1][2];
  assign rdy_s   = sync_q[SYNC_STAGES-1][3];

  assign start_rise = start_s & ~start_prev_q;
  assign fg_rise    = fg_db_q & ~fg_prev_q;
  assign ph_rise    = ph_s & ~ph_prev_q;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], {detector_ready, phase_signal, fg_signal, start_signal}};
    fg_db_d  = fg_db_q;
    db_cnt_d = '0;
    // fg level is only accepted after DEBOUNCE_CYCLES consecutive cycles of disagreement
    if (fg_s != fg_db_q) begin
      if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) fg_db_d = fg_s;
      else                                       db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_comb begin
    max_d  = '0;
    any_en = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (en_q[i]) begin
        any_en = 1'b1;
        if (dly_q[i*DLY_W +: DLY_W] > max_d) max_d = dly_q[i*DLY_W +: DLY_W];
      end
    end
    fire_end  = any_en ? (32'(max_d) + 32'(PULSE_CYCLES)) : 32'd0;
    shots_eff = (shots_q == '0) ? CNT_W'(1) : shots_q;
    hold_met  = (HOLDOFF_CYCLES == 0) || (tmr_q >= 32'(HOLDOFF_CYCLES - 1));
    tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmr_q == 32'(TIMEOUT_CYCLES - 1));
  end

  always_comb begin
    state_d  = state_q;
    ph_cnt_d = ph_cnt_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    shots_d  = shots_q;
    skip_d   = skip_q;
    dly_d    = dly_q;
    en_d     = en_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d = S_ARM;
          cnt_d   = '0;
          mode_d  = mode;
          shots_d = shot_count;
          skip_d  = phase_skip;
          dly_d   = channel_delay;
          en_d    = channel_enable;
        end
      end
      S_ARM: begin
        if (!start_s) state_d = S_IDLE;
        else if (fg_rise) begin
          state_d  = S_PHASE;
          ph_cnt_d = '0;
        end else if (tmo_hit) state_d = S_ERROR;
      end
      S_PHASE: begin
        if (!start_s)                state_d = S_IDLE;
        else if (ph_cnt_q == skip_q) state_d = S_FIRE;
        else if (ph_rise)            ph_cnt_d = ph_cnt_q + 1'b1;
      end
      S_FIRE: begin
        if (tmr_q == fire_end) begin
          state_d = S_HOLDOFF;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (hold_met && rdy_s) begin
          if (!start_s)            state_d = S_IDLE;
          else if (mode_q == 2'b10) state_d = S_ARM;
          else if (mode_q == 2'b01) state_d = (cnt_q >= shots_eff) ? S_DONE : S_ARM;
          else                     state_d = S_DONE;
        end
      end
      S_DONE, S_ERROR: begin
        if (!start_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // One shared timer: restarts on every state change, so each state sees elapsed cycles from 0
    if (state_d != state_q) tmr_d = '0;
    else if (tmr_q != '1)   tmr_d = tmr_q + 32'd1;
    else                    tmr_d = tmr_q;

    busy_d = (state_d != S_IDLE);
    tmo_d  = (state_d == S_ERROR);
  end

  always_comb begin
    trig_d = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      trig_d[i] = (state_q == S_FIRE) && en_q[i]
                  && (tmr_q >= 32'(dly_q[i*DLY_W +: DLY_W]))
                  && (tmr_q <  32'(dly_q[i*DLY_W +: DLY_W]) + 32'(PULSE_CYCLES));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      sync_q       <= '0;
      fg_db_q      <= 1'b0;
      db_cnt_q     <= '0;
      start_prev_q <= 1'b0;
      fg_prev_q    <= 1'b0;
      ph_prev_q    <= 1'b0;
      tmr_q        <= '0;
      ph_cnt_q     <= '0;
      mode_q       <= '0;
      shots_q      <= '0;
      skip_q       <= '0;
      dly_q        <= '0;
      en_q         <= '0;
      cnt_q        <= '0;
      trig_q       <= '0;
      busy_q       <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      fg_db_q      <= fg_db_d;
      db_cnt_q     <= db_cnt_d;
      start_prev_q <= start_s;
      fg_prev_q    <= fg_db_q;
      ph_prev_q    <= ph_s;
      tmr_q        <= tmr_d;
      ph_cnt_q     <= ph_cnt_d;
      mode_q       <= mode_d;
      shots_q      <= shots_d;
      skip_q       <= skip_d;
      dly_q        <= dly_d;
      en_q         <= en_d;
      cnt_q        <= cnt_d;
      trig_q       <= trig_d;
      busy_q       <= busy_d;
      tmo_q        <= tmo_d;
    end
  end

  assign output_trigger = trig_q;
  assign busy           = busy_q;
  assign scenario_state = state_q;
  assign counter_out    = cnt_q;
  assign timeout_error  = tmo_q;

endmodule

// File: tb/tb_fsm_calibration_multi.sv
// Randomized bench for fsm_calibration_multi against a shot-level reference model.
module tb_fsm_calibration_multi;
  localparam int NUM_CH = 4, CNT_W = 16, DLY_W = 12, PH_W = 8;
  localparam int SYNC = 2, DEB = 8, PUL = 4, HOLD = 64, TMO = 1000;

  logic clock = 1'b0, reset = 1'b0;
  logic start_signal = 1'b0, fg_signal = 1'b0, phase_signal = 1'b0, detector_ready = 1'b1;
  logic [1:0] mode = '0;
  logic [CNT_W-1:0] shot_count = '0;
  logic [PH_W-1:0] phase_skip = '0;
  logic [NUM_CH*DLY_W-1:0] channel_delay = '0;
  logic [NUM_CH-1:0] channel_enable = '0;
  logic [NUM_CH-1:0] output_trigger;
  logic busy, timeout_error;
  logic [2:0] scenario_state;
  logic [CNT_W-1:0] counter_out;

  int n_chk = 0, n_pass = 0;
  int m_mode, m_sc, m_skip, shots;
  int m_d[NUM_CH];
  bit m_en[NUM_CH];

  fsm_calibration_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DLY_W(DLY_W), .PH_W(PH_W), .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(PUL), .HOLDOFF_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .start_signal(start_signal), .fg_signal(fg_signal),
    .phase_signal(phase_signal), .detector_ready(detector_ready), .mode(mode),
    .shot_count(shot_count), .phase_skip(phase_skip), .channel_delay(channel_delay),
    .channel_enable(channel_enable), .output_trigger(output_trigger), .busy(busy),
    .scenario_state(scenario_state), .counter_out(counter_out), .timeout_error(timeout_error)
  );

  always #5 clock = ~clock;

  initial begin
    forever begin
      repeat (5) @(negedge clock);
      phase_signal = ~phase_signal;
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: got time-out expected completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] exp_mask(input int d, input bit en);
    logic [63:0] m;
    m = '0;
    if (en) for (int k = d + 1; k < d + 1 + PUL && k < 64; k++) m[k] = 1'b1;
    return m;
  endfunction

  function automatic int exp_fire_len();
    int mx;
    bit any;
    mx = 0; any = 0;
    for (int c = 0; c < NUM_CH; c++) if (m_en[c]) begin any = 1; if (m_d[c] > mx) mx = m_d[c]; end
    return any ? mx + PUL + 1 : 1;
  endfunction

  // state after HOLDOFF: 0 idle, 1 arm, 5 done
  function automatic int exp_next(input int md, input int sc, input int n, input bit st);
    if (!st) return 0;
    case (md)
      1:       return (n >= ((sc == 0) ? 1 : sc)) ? 5 : 1;
      2:       return 1;
      default: return 5;
    endcase
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_config();
    mode       = 2'(m_mode);
    shot_count = CNT_W'(m_sc);
    phase_skip = PH_W'(m_skip);
    for (int c = 0; c < NUM_CH; c++) begin
      channel_delay[c*DLY_W +: DLY_W] = DLY_W'(m_d[c]);
      channel_enable[c] = m_en[c];
    end
  endtask

  task automatic rand_config();
    m_mode = $urandom_range(0, 3);
    m_sc   = $urandom_range(0, 3);
    m_skip = $urandom_range(0, 4);
    for (int c = 0; c < NUM_CH; c++) begin
      m_d[c]  = $urandom_range(0, 30);
      m_en[c] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic scramble_inputs();
    mode = 2'($urandom); shot_count = CNT_W'($urandom); phase_skip = PH_W'($urandom);
    channel_delay = {$urandom, $urandom};
    channel_enable = 4'($urandom);
  endtask

  task automatic do_shot(input bit stop_now, output int nxt);
    int c, k, fire_len, hold_len, r;
    bit rdy_low;
    logic [63:0] mask [NUM_CH];
    fg_signal = 1'b1;
    c = 0;
    while (scenario_state !== 3'd3 && c < 3000) begin
      @(negedge clock); c++;
      if (c == 20) fg_signal = 1'b0;
    end
    fg_signal = 1'b0;
    if (scenario_state !== 3'd3) begin
      check_val("fire_reached", 64'(scenario_state), 64'd3);
      nxt = -1;
      return;
    end
    rdy_low = 1'($urandom_range(0, 1));
    r = HOLD + $urandom_range(0, 40);
    if (rdy_low) detector_ready = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) mask[ch] = '0;
    fire_len = 0; hold_len = 0; k = 0;
    while (k < 1000 && (scenario_state === 3'd3 || scenario_state === 3'd4)) begin
      if (k < 64) for (int ch = 0; ch < NUM_CH; ch++) mask[ch][k] = output_trigger[ch];
      if (scenario_state === 3'd3) fire_len++;
      else begin
        if (hold_len == 0) begin
          check_val("counter_out", 64'(counter_out), 64'(shots + 1));
          if (stop_now) start_signal = 1'b0;
        end
        if (rdy_low && hold_len == r) detector_ready = 1'b1;
        hold_len++;
      end
      @(negedge clock); k++;
    end
    detector_ready = 1'b1;
    shots++;
    for (int ch = 0; ch < NUM_CH; ch++)
      check_val($sformatf("mask_ch%0d", ch), mask[ch], exp_mask(m_d[ch], m_en[ch]));
    check_val("fire_len", 64'(fire_len), 64'(exp_fire_len()));
    check_val("hold_len", 64'(hold_len), rdy_low ? 64'(r + SYNC + 1) : 64'(HOLD));
    nxt = exp_next(m_mode, m_sc, shots, !stop_now);
    check_val("next_state", 64'(scenario_state), 64'(nxt));
  endtask

  task automatic run_one();
    int n, nxt;
    bit stop;
    drive_config();
    shots = 0;
    start_signal = 1'b1;
    cycles(5);
    check_val("arm_entry", 64'(scenario_state), 64'd1);
    check_val("counter_clr", 64'(counter_out), 64'd0);
    scramble_inputs();
    n = 0;
    do begin
      stop = (m_mode == 2) && (n == 1);
      do_shot(stop, nxt);
      n++;
    end while (nxt == 1 && n < 8);
    if (nxt == 5) check_val("done_busy", 64'(busy), 64'd1);
    start_signal = 1'b0;
    cycles(5);
    check_val("idle_after", 64'(scenario_state), 64'd0);
    check_val("idle_busy", 64'(busy), 64'd0);
    check_val("counter_hold", 64'(counter_out), 64'(shots));
  endtask

  initial begin
    int c, n;
    logic [NUM_CH-1:0] trig_seen;
    reset = 1'b0;
    cycles(3);
    check_val("rst_trig", 64'(output_trigger), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_state", 64'(scenario_state), 64'd0);
    check_val("rst_count", 64'(counter_out), 64'd0);
    check_val("rst_tmo", 64'(timeout_error), 64'd0);
    reset = 1'b1;
    cycles(3);

    // fg glitch shorter than the debounce window
    m_mode = 0; m_sc = 1; m_skip = 0;
    for (int ch = 0; ch < NUM_CH; ch++) begin m_d[ch] = 0; m_en[ch] = 1'b1; end
    drive_config();
    start_signal = 1'b1;
    cycles(5);
    fg_signal = 1'b1;
    cycles(DEB - 2);
    fg_signal = 1'b0;
    cycles(40);
    check_val("glitch_arm", 64'(scenario_state), 64'd1);
    start_signal = 1'b0;
    cycles(5);

    // timeout with no fast-gate edges
    start_signal = 1'b1;
    c = 0;
    while (scenario_state !== 3'd1 && c < 20) begin @(negedge clock); c++; end
    n = 0;
    while (scenario_state === 3'd1 && n < 3000) begin @(negedge clock); n++; end
    check_val("arm_cycles", 64'(n), 64'(TMO));
    check_val("err_state", 64'(scenario_state), 64'd6);
    check_val("err_flag", 64'(timeout_error), 64'd1);
    start_signal = 1'b0;
    cycles(5);
    check_val("err_idle", 64'(scenario_state), 64'd0);
    check_val("err_clr", 64'(timeout_error), 64'd0);

    // continuous, start dropped mid-PHASE
    m_mode = 2; m_skip = 200;
    drive_config();
    start_signal = 1'b1;
    cycles(5);
    fg_signal = 1'b1;
    c = 0;
    while (scenario_state !== 3'd2 && c < 200) begin
      @(negedge clock); c++;
      if (c == 20) fg_signal = 1'b0;
    end
    check_val("phase_reached", 64'(scenario_state), 64'd2);
    cycles(5);
    start_signal = 1'b0;
    fg_signal = 1'b0;
    trig_seen = '0;
    n = 0;
    while (scenario_state !== 3'd0 && n < 50) begin
      @(negedge clock); n++;
      trig_seen |= output_trigger;
    end
    check_val("drop_latency", 64'(n), 64'(SYNC + 1));
    check_val("drop_busy", 64'(busy), 64'd0);
    check_val("drop_trig", 64'(trig_seen), 64'd0);
    cycles(5);

    for (int run = 0; run < 8; run++) begin
      rand_config();
      run_one();
      cycles(10);
    end

    // reset asserted while ch2 is pulsing
    m_mode = 0; m_sc = 1; m_skip = 1;
    for (int ch = 0; ch < NUM_CH; ch++) begin m_d[ch] = 0; m_en[ch] = 1'b0; end
    m_d[2] = 5; m_en[2] = 1'b1;
    drive_config();
    start_signal = 1'b1;
    cycles(5);
    fg_signal = 1'b1;
    c = 0;
    while (output_trigger[2] !== 1'b1 && c < 3000) begin
      @(negedge clock); c++;
      if (c == 20) fg_signal = 1'b0;
    end
    fg_signal = 1'b0;
    check_val("ch2_high", 64'(output_trigger), 64'b0100);
    reset = 1'b0;
    #1;
    check_val("arst_trig", 64'(output_trigger), 64'd0);
    check_val("arst_state", 64'(scenario_state), 64'd0);
    check_val("arst_busy", 64'(busy), 64'd0);
    check_val("arst_count", 64'(counter_out), 64'd0);
    start_signal = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    cycles(5);
    run_one();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fsm_calibration_multi.md
# fsm_calibration_multi

Parametrised multi-channel successor to the single-output calibration sequencer. It arms on `start_signal` and waits for a debounced fast-gate edge. It then counts a programmable number of phase-reference edges and fires `NUM_CH` trigger pulses, each with its own delay. It repeats per the selected mode (single, burst, continuous), gated by detector readiness, and reports state, shot count and a fast-gate timeout error to the synchronization block's control/readout logic.

## Interface
- `NUM_CH`, 4: number of trigger output channels.
- `CNT_W`, 16: width of shot counter and `shot_count`.
- `DLY_W`, 12: width of each per-channel delay, in clock cycles.
- `PH_W`, 8: width of `phase_skip`.
- `SYNC_STAGES`, 2: synchroniser depth on all asynchronous inputs (≥2).
- `DEBOUNCE_CYCLES`, 8: cycles `fg_signal` must be stable before its level is accepted.
- `PULSE_CYCLES`, 4: trigger pulse width (≥1).
- `HOLDOFF_CYCLES`, 1024: minimum cycles between shots.
- `TIMEOUT_CYCLES`, 8_000_000: max cycles in ARM waiting for fast gate; 0 disables.

Ports:
- `clock` in 1: single system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low; all state cleared while low.
- `start_signal` in 1: async run request.
- `fg_signal` in 1: async fast-gate opto level.
- `phase_signal` in 1: async phase reference.
- `detector_ready` in 1: async; high when the detector can accept a shot.
- `mode` in 2: 00 single, 01 burst, 10 continuous, 11 treated as single.
- `shot_count` in CNT_W: burst length; 0 treated as 1.
- `phase_skip` in PH_W: phase rising edges to count after fast-gate edge (0 = fire on the next cycle).
- `channel_delay` in NUM_CH*DLY_W: delay of channel i at bits [i*DLY_W +: DLY_W].
- `channel_enable` in NUM_CH: per-channel enable.
- `output_trigger` out NUM_CH: trigger pulses.
- `busy` out 1: high in any state except IDLE.
- `scenario_state` out 3: current state encoding.
- `counter_out` out CNT_W: completed shots in the current run.
- `timeout_error` out 1: high in ERROR.

## Operation
- All async inputs pass through SYNC_STAGES flops; `fg_signal` is then debounced; rising edges are detected on the synchronised/debounced levels.
- `mode`, `shot_count`, `phase_skip`, `channel_delay`, `channel_enable` are sampled on the ARM entry from IDLE and held for the run.
- States/encoding: IDLE=0, ARM=1, PHASE=2, FIRE=3, HOLDOFF=4, DONE=5, ERROR=6.
- IDLE: start rising edge → ARM; clears `counter_out` and the timeout counter.
- ARM: fg rising edge → PHASE (phase-edge counter cleared). Start low → IDLE. Timeout counter reaching TIMEOUT_CYCLES (non-zero) → ERROR.
- PHASE: counts phase rising edges. Count == `phase_skip` → FIRE. Start low → IDLE. With `phase_skip`=0, FIRE follows on the next cycle.
- FIRE: delay counter runs from 0. Enabled channel i is high for cycles [d_i, d_i+PULSE_CYCLES). Exit occurs at counter == max(enabled d_i)+PULSE_CYCLES, or after 1 cycle if no channel is enabled. On exit, `counter_out` increments (saturating) → HOLDOFF. Start falling does not truncate pulses.
- HOLDOFF: exits once ≥HOLDOFF_CYCLES have elapsed and synchronised `detector_ready`=1. Then:
  - single → DONE.
  - burst → DONE if counter_out ≥ shot_count, else ARM.
  - continuous → ARM if start high, else IDLE.
  - In single or burst, start low at exit → IDLE.
- DONE / ERROR: hold until start low → IDLE. `counter_out` holds its value in DONE and IDLE until the next run.
- Disabled channels never pulse. Channels with equal delays pulse simultaneously.

## Timing
- Reset values: `output_trigger`=0, `busy`=0, `scenario_state`=0, `counter_out`=0, `timeout_error`=0. All counters and synchronisers are 0.
- Input edge latency: SYNC_STAGES+1 cycles to the state transition; fg adds DEBOUNCE_CYCLES.
- Output latency: all outputs registered. Channel i first goes high d_i+1 cycles after `scenario_state` shows FIRE.
- Reset asserted mid-FIRE: triggers drop immediately (async).
- `counter_out` updates in the same cycle `scenario_state` becomes HOLDOFF.

## Test plan
- Single mode, phase_skip=3, enables=4'b0011, delays 0/10, start high for 30 ms with fg every 10 ms → exactly one shot. ch0 fires, then ch1 10 cycles later, each 4 cycles wide; counter_out=1; state ends in DONE, then IDLE after start low.
- Burst shot_count=3, detector_ready low for 6.4 ms after each trigger → 3 shots, each spaced by one fg period; none fire while ready is low; counter_out=3.
- Continuous mode, start dropped mid-PHASE → no trigger; IDLE within SYNC_STAGES+2 cycles; busy=0.
- No fg edges, TIMEOUT_CYCLES=1000 → ERROR (state 6, timeout_error=1) after 1000 ARM cycles; start low → IDLE.
- fg glitch shorter than DEBOUNCE_CYCLES → no transition out of ARM.
- Reset pulsed low while ch2 is high in FIRE → all outputs 0 the same instant; subsequent start runs normally from counter_out=0.
